mips_cpu_lsu: RTL

Parametrised load/store unit placed between the multicycle CPU core's MEM state and the Avalon memory-mapped master port. It accepts one load/store request at a time and handles address-dependent byte lanes, sign/zero extension and LWL/LWR merging. It honours waitrequest and flags misaligned or illegal accesses without issuing a bus cycle.

---
 rtl/mips_cpu_lsu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the multicycle core's MEM state and an Avalon-MM master.
// One request in flight; byte-lane steering, sign/zero extension, LWL/LWR merge.
// Misaligned or illegal requests answer with resp_err and never touch the bus.
// Optional: define LSU_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES stalls.
module mips_cpu_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LW = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6,
                         OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;

  state_t r_state, w_state_nxt;
  logic [3:0]        r_op;
  logic [1:0]        r_k;
  logic [31:0]       r_rt_old;
  logic              r_read, r_write, r_resp_valid, r_resp_err;
  logic [ADDR_W-1:0] r_address;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_resp_data;

  logic [1:0]  w_k;
  logic        w_is_load, w_is_store, w_err, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_load, w_rd_sh;
  logic [4:0]  w_lwl_sh;

  assign w_k       = req_addr[1:0];
  assign req_ready = (r_state == S_IDLE);
  assign read      = r_read;
  assign write     = r_write;
  assign address   = r_address;
  assign byteenable = r_be;
  assign writedata = r_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_err  = r_resp_err;
  assign resp_data = r_resp_data;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  // Count stalled BUS cycles; held at zero outside BUS so every bus cycle starts fresh.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_BUS) r_tmo_cnt <= '0;
    else if (waitrequest)        r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end
  assign w_tmo = (r_state == S_BUS) && waitrequest && (r_tmo_cnt + 32'd1 >= 32'(TIMEOUT_CYCLES));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo = 1'b0;
`endif

  // Decode the incoming request: legality, lane enables, replicated store data.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_err      = 1'b0;
    w_be       = 4'b0000;
    w_wd       = 32'd0;
    case (req_op)
      OP_LB, OP_LBU: begin w_is_load = 1'b1; w_be = 4'b0001 << w_k; end
      OP_LH, OP_LHU: begin w_is_load = 1'b1; w_be = 4'b0011 << w_k; w_err = w_k[0]; end
      OP_LW:         begin w_is_load = 1'b1; w_be = 4'b1111; w_err = (w_k != 2'd0); end
      OP_LWL:        begin w_is_load = 1'b1; w_be = (4'b0010 << w_k) - 4'd1; end
      OP_LWR:        begin w_is_load = 1'b1; w_be = 4'b1111 << w_k; end
      OP_SB: begin w_is_store = 1'b1; w_be = 4'b0001 << w_k; w_wd = {4{req_wdata[7:0]}}; end
      OP_SH: begin w_is_store = 1'b1; w_be = 4'b0011 << w_k; w_wd = {2{req_wdata[15:0]}};
                   w_err = w_k[0]; end
      OP_SW: begin w_is_store = 1'b1; w_be = 4'b1111; w_wd = req_wdata; w_err = (w_k != 2'd0); end
      default: w_err = 1'b1;
    endcase
  end

  assign w_rd_sh  = readdata >> {r_k, 3'b000};
  assign w_lwl_sh = {~r_k, 3'b000};

  // Shape the returned word into the load result; stores return zero.
  always_comb begin
    w_load = 32'd0;
    case (r_op)
      OP_LB:  w_load = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
      OP_LBU: w_load = {24'd0, w_rd_sh[7:0]};
      OP_LH:  w_load = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
      OP_LHU: w_load = {16'd0, w_rd_sh[15:0]};
      OP_LW:  w_load = readdata;
      OP_LWL: w_load = (readdata << w_lwl_sh) | (r_rt_old & ~(32'hFFFF_FFFF << w_lwl_sh));
      OP_LWR: w_load = w_rd_sh | (r_rt_old & ~(32'hFFFF_FFFF >> {r_k, 3'b000}));
      default: w_load = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: errors skip the bus, a bus cycle ends on !waitrequest or timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = w_err ? S_RESP : S_BUS;
      S_BUS:  if (!waitrequest || w_tmo) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered bus and response outputs; bus signals only change at accept or completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0; r_k <= '0; r_rt_old <= '0;
      r_read <= 1'b0; r_write <= 1'b0; r_address <= '0; r_be <= '0; r_wdata <= '0;
      r_resp_valid <= 1'b0; r_resp_err <= 1'b0; r_resp_data <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_resp_data <= '0;
          if (req_valid) begin
            r_op     <= req_op;
            r_k      <= w_k;
            r_rt_old <= req_rt_old;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_read    <= w_is_load;
              r_write   <= w_is_store;
              r_address <= {req_addr[ADDR_W-1:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wd;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            r_read <= 1'b0; r_write <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_load;
          end else if (w_tmo) begin
            r_read <= 1'b0; r_write <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
